// File: rtl/gpio_mmio_pkg.sv
// gpio_mmio_pkg
// Shared definitions for the memory-mapped GPIO block: size of the IO
// register window at the top of the address space, register offsets within
// that window, and the 7-segment digit nibble type.
package gpio_mmio_pkg;

  // IO window occupies the last IO_WIN bytes of the address space.
  localparam int IO_WIN = 16;

  // Register offsets from IO_BASE.
  localparam logic [3:0] OFF_BTN    = 4'h0;
  localparam logic [3:0] OFF_EVT    = 4'h1;
  localparam logic [3:0] OFF_IE     = 4'h2;
  localparam logic [3:0] OFF_SW_LO  = 4'h3;
  localparam logic [3:0] OFF_SW_HI  = 4'h4;
  localparam logic [3:0] OFF_LED_LO = 4'h5;
  localparam logic [3:0] OFF_LED_HI = 4'h6;
  localparam logic [3:0] OFF_DIG0   = 4'h8;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce
// Per-bit 2-flop synchroniser followed by a debounce counter. A new level is
// accepted only after the synchronised input has disagreed with the current
// debounced level for DB_CYCLES consecutive cycles.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset (clears sync flops, counters, output)
//   raw_i  - asynchronous raw inputs
//   db_o   - debounced levels (registered)
module gpio_debounce
  import gpio_mmio_pkg::*;
#(
  parameter int W         = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] db_o
);

  localparam int            CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    logic [CW-1:0] cnt_q;
    logic          db_q;

    // cnt_q counts mismatch cycles already seen; the DB_CYCLES-th mismatch
    // (cnt_q == DB_CYCLES-1) flips the level instead of counting further.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else if (sync2_q[gi] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        db_q  <= ~db_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign db_o[gi] = db_q;
  end

endmodule

// File: rtl/gpio_mmio.sv
// gpio_mmio
// Byte-wide memory-mapped peripheral: RAM below IO_BASE, a 16-byte register
// window above it (buttons, sticky button events, interrupt enable, switches,
// LEDs, 7-segment digit nibbles). Reads are registered with one-cycle latency
// and return the pre-write value when a write hits the same address.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   we          - 1 = write wdata to addr this cycle (a read happens every cycle)
//   addr, wdata - byte address / write data
//   rdata       - registered read data
//   buttons     - raw asynchronous buttons
//   switches    - raw asynchronous switches
//   leds        - LED drive
//   digits      - digit nibbles, digit i = digits[4i+3:4i]
//   irq         - registered level interrupt, |(EVT & IE)
module gpio_mmio
  import gpio_mmio_pkg::*;
#(
  parameter int    ADDR_W    = 9,
  parameter int    N_BTN     = 4,
  parameter int    N_SW      = 16,
  parameter int    N_LED     = 16,
  parameter int    N_DIG     = 4,
  parameter int    DB_CYCLES = 16,
  parameter string INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  input  logic [N_BTN-1:0]   buttons,
  input  logic [N_SW-1:0]    switches,
  output logic [N_LED-1:0]   leds,
  output logic [4*N_DIG-1:0] digits,
  output logic               irq
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int IO_BASE = DEPTH - IO_WIN;

  logic [7:0]       mem [IO_BASE];
  logic [7:0]       rdata_q;
  logic [7:0]       io_rd;
  logic [N_BTN-1:0] btn_db, btn_prev_q, evt_q, evt_d, ie_q, ie_d;
  logic [N_SW-1:0]  sw_db;
  logic [N_LED-1:0] led_q, led_d;
  logic [15:0]      led_rd, led_wr, sw_rd;
  nibble_t          dig_q [N_DIG];
  nibble_t          dig_d [N_DIG];
  logic             irq_q;
  logic             is_io, io_wr;
  logic [3:0]       off;

  gpio_debounce #(.W(N_BTN), .DB_CYCLES(DB_CYCLES)) u_btn_db (
    .clk  (clk),
    .reset(reset),
    .raw_i(buttons),
    .db_o (btn_db)
  );

  gpio_debounce #(.W(N_SW), .DB_CYCLES(DB_CYCLES)) u_sw_db (
    .clk  (clk),
    .reset(reset),
    .raw_i(switches),
    .db_o (sw_db)
  );

  assign is_io  = (addr >= ADDR_W'(IO_BASE));
  assign off    = addr[3:0];
  assign io_wr  = we && is_io;
  assign led_rd = 16'(led_q);
  assign sw_rd  = 16'(sw_db);

  // Register-window read mux; only selected when addr is in the IO window.
  always_comb begin
    io_rd = '0;
    case (off)
      OFF_BTN:    io_rd = 8'(btn_db);
      OFF_EVT:    io_rd = 8'(evt_q);
      OFF_IE:     io_rd = 8'(ie_q);
      OFF_SW_LO:  io_rd = sw_rd[7:0];
      OFF_SW_HI:  io_rd = sw_rd[15:8];
      OFF_LED_LO: io_rd = led_rd[7:0];
      OFF_LED_HI: io_rd = led_rd[15:8];
      default: begin
        for (int i = 0; i < N_DIG; i++) begin
          if (off == 4'(OFF_DIG0 + i)) io_rd = {4'h0, dig_q[i]};
        end
      end
    endcase
  end

  always_comb begin
    // Clear by W1C first, then OR in new rising edges so a coincident set wins.
    evt_d = evt_q;
    if (io_wr && off == OFF_EVT) evt_d = evt_q & ~wdata[N_BTN-1:0];
    evt_d = evt_d | (btn_db & ~btn_prev_q);

    ie_d = ie_q;
    if (io_wr && off == OFF_IE) ie_d = wdata[N_BTN-1:0];

    led_wr = led_rd;
    if (io_wr && off == OFF_LED_LO) led_wr[7:0]  = wdata;
    if (io_wr && off == OFF_LED_HI) led_wr[15:8] = wdata;
    led_d = led_wr[N_LED-1:0];

    dig_d = dig_q;
    for (int i = 0; i < N_DIG; i++) begin
      if (io_wr && off == 4'(OFF_DIG0 + i)) dig_d[i] = wdata[3:0];
    end
  end

  // RAM: write below IO_BASE only; kept in its own block so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (we && !reset && !is_io) mem[addr] <= wdata;
  end

  // Registered read; nonblocking semantics give the old RAM value on a
  // same-address write.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= is_io ? io_rd : mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q      <= '0;
      ie_q       <= '0;
      led_q      <= '0;
      dig_q      <= '{default: '0};
      irq_q      <= 1'b0;
      btn_prev_q <= '0;
    end else begin
      evt_q      <= evt_d;
      ie_q       <= ie_d;
      led_q      <= led_d;
      dig_q      <= dig_d;
      irq_q      <= |(evt_q & ie_q);
      btn_prev_q <= btn_db;
    end
  end

  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
    assign digits[4*gi +: 4] = dig_q[gi];
  end

  assign rdata = rdata_q;
  assign leds  = led_q;
  assign irq   = irq_q;

endmodule
